// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: default widths, starvation
// limit, counter width and requester port indices.
`timescale 1ns/1ps

package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned DEPTH_DEF      = 256;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned STARVE_CNT_W   = 4;
    localparam int unsigned N_PORTS        = 2;

    // Requester indices into the grant vector
    localparam logic P_PIPE = 1'b0;
    localparam logic P_LOAD = 1'b1;

    // True when one more denied cycle brings the wait count up to the limit
    function automatic logic starve_hit(input logic [STARVE_CNT_W-1:0] cnt,
                                        input int unsigned            max_wait);
        return ((STARVE_CNT_W+1)'(cnt) + (STARVE_CNT_W+1)'(1)) == (STARVE_CNT_W+1)'(max_wait);
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating wait counter with a one-shot force flag. Counts consecutive
// cycles in which a requester is denied and raises force_gnt once the count
// reaches STARVE_MAX, so the owner of the shared resource can override
// priority for one grant.
`timescale 1ns/1ps

module dmem_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic force_gnt
);

    logic [STARVE_CNT_W-1:0] cnt;
    logic [STARVE_CNT_W-1:0] cnt_nxt;
    logic                    force_nxt;

    // Count only while waiting; a grant or a dropped request clears both
    always_comb begin
        cnt_nxt   = '0;
        force_nxt = 1'b0;
        if (req && !gnt) begin
            cnt_nxt   = (cnt == '1) ? cnt : cnt + STARVE_CNT_W'(1);
            force_nxt = starve_hit(cnt, STARVE_MAX);
        end
    end

    // Counter and force flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            force_gnt <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            force_gnt <= force_nxt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the 256-word data memory. Port 0 (pipeline)
// has fixed priority; port 1 (loader/debug) is guaranteed a grant after
// STARVE_MAX consecutive denied cycles. Read data is registered back to the
// port that owned the access.
// Optional build macro DMEM_ARB_BOUNDS_CHK_EN: accesses with address bits
// above the memory index are suppressed and flagged on pN_err.
`timescale 1ns/1ps

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_stall,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
`ifdef DMEM_ARB_BOUNDS_CHK_EN
    output logic              p0_err,
    output logic              p1_err,
`endif
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Reject configurations the counter or index split cannot represent
    if (STARVE_MAX < 1 || STARVE_MAX > 15 || (1 << IDX_W) != DEPTH) begin : g_cfg_err
        $error("dmem_arbiter: unsupported DEPTH or STARVE_MAX");
    end

    logic [N_PORTS-1:0] gnt;
    logic               force_p1;
    logic               any_gnt;
    logic               bad_addr;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    dmem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .req       (p1_req),
        .gnt       (gnt[P_LOAD]),
        .force_gnt (force_p1)
    );

    // Fixed priority with a starvation override; nothing is granted in reset
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (force_p1 && p1_req) begin
                gnt[P_LOAD] = 1'b1;
            end else if (p0_req) begin
                gnt[P_PIPE] = 1'b1;
            end else if (p1_req) begin
                gnt[P_LOAD] = 1'b1;
            end
        end
    end

    assign p0_gnt   = gnt[P_PIPE];
    assign p1_gnt   = gnt[P_LOAD];
    assign p0_stall = p0_req & ~gnt[P_PIPE];
    assign any_gnt  = |gnt;

    // Route the granted port's request onto the memory pins
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[P_PIPE]) begin
            sel_we    = p0_we;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end else if (gnt[P_LOAD]) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

`ifdef DMEM_ARB_BOUNDS_CHK_EN
    assign bad_addr = any_gnt & (|sel_addr[ADDR_W-1:IDX_W]);
`else
    assign bad_addr = 1'b0;
`endif

    assign mem_read  = any_gnt & ~sel_we & ~bad_addr;
    assign mem_write = any_gnt &  sel_we & ~bad_addr;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;

    // Return read data (or a zeroed error response) to the owning port
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= gnt[P_PIPE] & ~p0_we;
            p1_rvalid <= gnt[P_LOAD] & ~p1_we;
            if (gnt[P_PIPE] && !p0_we) begin
                p0_rdata <= bad_addr ? '0 : mem_rdata;
            end
            if (gnt[P_LOAD] && !p1_we) begin
                p1_rdata <= bad_addr ? '0 : mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_BOUNDS_CHK_EN
    // One-cycle error pulse for an out-of-range granted access
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_err <= 1'b0;
            p1_err <= 1'b0;
        end else begin
            p0_err <= gnt[P_PIPE] & bad_addr;
            p1_err <= gnt[P_LOAD] & bad_addr;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of the arbitration rules and an
// array image of the memory. Honours DMEM_ARB_BOUNDS_CHK_EN when defined.
`timescale 1ns/1ps

module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int          SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
`ifdef DMEM_ARB_BOUNDS_CHK_EN
    logic          p0_err, p1_err;
`endif
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            due;
        logic          rv;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          sb0[$];
    rsp_t          sb1[$];
    logic [DW-1:0] ref_mem [256];
    int            denied_run = 0;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(256), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
`ifdef DMEM_ARB_BOUNDS_CHK_EN
        .p0_err(p0_err), .p1_err(p1_err),
`endif
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    endfunction

    // External memory: combinational read, write at the clock edge
    logic [DW-1:0] ext_mem [256];
    bit            ext_written [256];
    assign mem_rdata = ext_written[mem_addr[7:0]] ? ext_mem[mem_addr[7:0]]
                                                  : init_word(int'(mem_addr[7:0]));
    always @(posedge clk) begin
        if (mem_write) begin
            ext_mem[mem_addr[7:0]]     <= mem_wdata;
            ext_written[mem_addr[7:0]] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = {24'(0), 8'($urandom_range(0, 15))};
        if ($urandom_range(0, 7) == 0) a[AW-1:8] = 24'($urandom);
        return a;
    endfunction

    // One cycle of stimulus; model predicts grants, memory pins and responses
    task automatic step(input logic r,
                        input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        output logic g0, output logic g1);
        logic          g, sw, bad;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        rsp_t          e;
        @(negedge clk);
        rst = r;
        p0_req = q0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = q1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
        g1 = !r && q1 && (!q0 || denied_run >= SMAX);
        g0 = !r && q0 && !g1;
        g  = g0 || g1;
        sw = g0 ? w0 : (g1 ? w1 : 1'b0);
        sa = g0 ? a0 : (g1 ? a1 : '0);
        sd = g0 ? d0 : (g1 ? d1 : '0);
`ifdef DMEM_ARB_BOUNDS_CHK_EN
        bad = g && (sa[AW-1:8] != '0);
`else
        bad = 1'b0;
`endif
        check("p0_gnt", 64'(p0_gnt), 64'(g0));
        check("p1_gnt", 64'(p1_gnt), 64'(g1));
        check("p0_stall", 64'(p0_stall), 64'(q0 && !g0));
        check("mem_read", 64'(mem_read), 64'(g && !sw && !bad));
        check("mem_write", 64'(mem_write), 64'(g && sw && !bad));
        check("mem_addr", 64'(mem_addr), 64'(sa));
        check("mem_wdata", 64'(mem_wdata), 64'(sd));
        if (g && (!sw || bad)) begin
            e.due  = cyc + 1;
            e.rv   = !sw;
            e.err  = bad;
            e.data = bad ? '0 : ref_mem[sa[7:0]];
            if (g0) sb0.push_back(e);
            else    sb1.push_back(e);
        end
        if (g && sw && !bad) ref_mem[sa[7:0]] = sd;
        if (r || !q1 || g1) denied_run = 0;
        else                denied_run++;
        if (r) begin
            sb0.delete();
            sb1.delete();
        end
    endtask

    task automatic idle();
        logic g0, g1;
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, g0, g1);
    endtask

    // Port 0 loads every cycle while port 1 waits; returns the grant cycle
    task automatic run_starve(input logic idle_first, input logic w, input logic [DW-1:0] d,
                              output int waited);
        logic g0, g1;
        if (idle_first) idle();
        waited = 99;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd2, '0, 1'b1, w, 32'd3, d, g0, g1);
            if (g1) begin
                waited = i;
                break;
            end
        end
    endtask

    // Monitor: pops the scoreboard when a response is due, else expects silence
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (sb0.size() > 0 && sb0[0].due == cyc) begin
                r = sb0.pop_front();
                check("p0_rvalid", 64'(p0_rvalid), 64'(r.rv));
                if (r.rv) check("p0_rdata", 64'(p0_rdata), 64'(r.data));
`ifdef DMEM_ARB_BOUNDS_CHK_EN
                check("p0_err", 64'(p0_err), 64'(r.err));
`endif
            end else begin
                check("p0_rvalid_idle", 64'(p0_rvalid), 64'(0));
`ifdef DMEM_ARB_BOUNDS_CHK_EN
                check("p0_err_idle", 64'(p0_err), 64'(0));
`endif
            end
            if (sb1.size() > 0 && sb1[0].due == cyc) begin
                r = sb1.pop_front();
                check("p1_rvalid", 64'(p1_rvalid), 64'(r.rv));
                if (r.rv) check("p1_rdata", 64'(p1_rdata), 64'(r.data));
`ifdef DMEM_ARB_BOUNDS_CHK_EN
                check("p1_err", 64'(p1_err), 64'(r.err));
`endif
            end else begin
                check("p1_rvalid_idle", 64'(p1_rvalid), 64'(0));
`ifdef DMEM_ARB_BOUNDS_CHK_EN
                check("p1_err_idle", 64'(p1_err), 64'(0));
`endif
            end
        end
    end

    // Stimulus
    initial begin
        logic          g0, g1, c0q, c0w, c1q, c1w;
        logic [AW-1:0] c0a, c1a;
        logic [DW-1:0] c0d, c1d;
        int            waited;

        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (2) @(negedge clk);
        check("reset_p0_rdata", 64'(p0_rdata), 64'(0));
        check("reset_p1_rdata", 64'(p1_rdata), 64'(0));
        check("reset_mem_addr", 64'(mem_addr), 64'(0));
        idle();

        // Loader write then read-back of the same word
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, g0, g1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd5, '0, g0, g1);
        idle();
        check("loader_readback", 64'(p1_rdata), 64'(32'hDEAD_BEEF));

        // Simultaneous requests: pipeline wins, loader follows
        step(1'b0, 1'b1, 1'b0, 32'd20, '0, 1'b1, 1'b0, 32'd30, '0, g0, g1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd30, '0, g0, g1);
        idle();

        // Starvation guard: two back-to-back waits of the same length
        run_starve(1'b1, 1'b0, '0, waited);
        check("starve_wait_first", 64'(waited), 64'(5));
        run_starve(1'b0, 1'b0, '0, waited);
        check("starve_wait_again", 64'(waited), 64'(5));
        idle();

        // Read vs write to the same word in one cycle: old value, then new
        step(1'b0, 1'b1, 1'b0, 32'd10, '0, 1'b1, 1'b1, 32'd10, 32'h1234, g0, g1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd10, 32'h1234, g0, g1);
        check("collide_old_value", 64'(p0_rdata), 64'(init_word(10)));
        step(1'b0, 1'b1, 1'b0, 32'd10, '0, 1'b0, 1'b0, '0, '0, g0, g1);
        idle();
        check("collide_new_value", 64'(p0_rdata), 64'(32'h1234));

        // Reset while the loader has waited three cycles
        idle();
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'd2, '0, 1'b1, 1'b1, 32'd7, 32'hCAFE, g0, g1);
        step(1'b1, 1'b1, 1'b0, 32'd2, '0, 1'b1, 1'b1, 32'd7, 32'hCAFE, g0, g1);
        check("reset_mid_p1_rvalid", 64'(p1_rvalid), 64'(0));
        run_starve(1'b0, 1'b1, 32'hCAFE, waited);
        check("starve_after_reset", 64'(waited), 64'(5));
        idle();

`ifdef DMEM_ARB_BOUNDS_CHK_EN
        // Out-of-range pipeline read is suppressed and flagged
        step(1'b0, 1'b1, 1'b0, 32'h100, '0, 1'b0, 1'b0, '0, '0, g0, g1);
        idle();
        check("bounds_err", 64'(p0_err), 64'(1));
        check("bounds_rvalid", 64'(p0_rvalid), 64'(1));
        check("bounds_rdata", 64'(p0_rdata), 64'(0));
`endif

        // Random traffic, holding each stalled request stable
        c0q = 1'b0; c0w = 1'b0; c0a = '0; c0d = '0;
        c1q = 1'b0; c1w = 1'b0; c1a = '0; c1d = '0;
        g0 = 1'b0; g1 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!(c0q && !g0)) begin
                c0q = ($urandom_range(0, 9) < 6);
                c0w = 1'($urandom_range(0, 1));
                c0a = rand_addr();
                c0d = $urandom;
            end
            if (!(c1q && !g1)) begin
                c1q = ($urandom_range(0, 1) == 1);
                c1w = 1'($urandom_range(0, 1));
                c1a = rand_addr();
                c1d = $urandom;
            end
            step(($urandom_range(0, 99) == 0), c0q, c0w, c0a, c0d, c1q, c1w, c1a, c1d, g0, g1);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
